// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_pkg
//  Description : Shared widths, FSM state type and helpers for the RSA
//                multiply primitive (mul_3232 and its step adder).
//  Contents    : OP_W  - operand width (32)
//                RES_W - product width (64)
//                CNT_W - step counter width (6, counts 0..32)
//                state_t - LOAD / RUN / DONE
//                zext_op - zero-extend an operand to product width
//  Revision    : 1.0 - initial release
// ============================================================================
package rsa_pkg;

    localparam int OP_W  = 32;
    localparam int RES_W = 64;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [RES_W-1:0] zext_op(input logic [OP_W-1:0] v);
        return {{(RES_W-OP_W){1'b0}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_3232_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_3232_if
//  Description : Operand/result bundle of the sequential 32x32 multiplier.
//  Signals     : ina     [31:0] multiplicand, unsigned
//                inb     [31:0] multiplier, unsigned
//                result  [63:0] product register (0 until done)
//                ready_n        active-low done flag
//  Modports    : master - drives operands, observes result
//                slave  - the multiplier itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul_3232_if;
    import rsa_pkg::*;

    logic [OP_W-1:0]  ina;
    logic [OP_W-1:0]  inb;
    logic [RES_W-1:0] result;
    logic             ready_n;

    modport master (
        output ina,
        output inb,
        input  result,
        input  ready_n
    );

    modport slave (
        input  ina,
        input  inb,
        output result,
        output ready_n
    );

endinterface
`default_nettype wire

// File: rtl/mul_3232_step.sv
`default_nettype none
// ============================================================================
//  Module      : mul_3232_step
//  Description : One combinational shift-and-add step:
//                o_sum = i_acc + (i_bit ? i_a << i_idx : 0), mod 2^64.
//  Ports       : i_acc [63:0] running accumulator
//                i_a   [63:0] zero-extended multiplicand
//                i_bit        current multiplier bit
//                i_idx [4:0]  bit position / shift amount
//                o_sum [63:0] updated accumulator
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_3232_step
    import rsa_pkg::*;
(
    input  wire logic [RES_W-1:0] i_acc,
    input  wire logic [RES_W-1:0] i_a,
    input  wire logic             i_bit,
    input  wire logic [4:0]       i_idx,
    output logic      [RES_W-1:0] o_sum
);

    logic [RES_W-1:0] w_partial;

    assign w_partial = i_bit ? (i_a << i_idx) : '0;
    assign o_sum     = i_acc + w_partial;

endmodule
`default_nettype wire

// File: rtl/mul_3232.sv
`default_nettype none
// ============================================================================
//  Module      : mul_3232
//  Description : Sequential unsigned 32x32->64 shift-and-add multiplier.
//                Operands are captured on the first edge after reset
//                release, one multiplier bit is consumed per clock, and the
//                product appears with ready_n low on the 33rd edge. The
//                product is then held until the next reset.
//  Ports       : clk   rising-edge clock
//                rst_n synchronous reset, ACTIVE-HIGH despite its name
//                bus   mul_3232_if.slave (ina, inb, result, ready_n)
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_3232
    import rsa_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst_n,
    mul_3232_if.slave   bus
);

    state_t             r_state;
    logic [RES_W-1:0]   r_a;
    logic [OP_W-1:0]    r_b;
    logic [RES_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [RES_W-1:0]   r_result;
    logic               r_ready_n;

    logic               w_bit;
    logic [4:0]         w_idx;
    logic [RES_W-1:0]   w_sum;

    // Counter never exceeds 31 while in RUN, so the low five bits are the
    // full step index there.
    assign w_idx = r_cnt[4:0];
    assign w_bit = r_b[w_idx];

    mul_3232_step u_step (
        .i_acc (r_acc),
        .i_a   (r_a),
        .i_bit (w_bit),
        .i_idx (w_idx),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state   <= LOAD;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_ready_n <= 1'b1;
        end else begin
            case (r_state)
                LOAD: begin
                    r_a     <= zext_op(bus.ina);
                    r_b     <= bus.inb;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // The result register is written only here, so partial
                    // sums are never visible on the output.
                    if (r_cnt == CNT_W'(OP_W - 1)) begin
                        r_result  <= w_sum;
                        r_ready_n <= 1'b0;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

    assign bus.result  = r_result;
    assign bus.ready_n = r_ready_n;

endmodule
`default_nettype wire

// File: tb/tb_mul_3232.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_3232
//  Description : Self-checking bench for mul_3232: directed vector table,
//                hold / reset-in-DONE / abort sequences and random operands
//                against a 64-bit golden product.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_3232;

    logic clk;
    logic rst_n;

    mul_3232_if u_if ();

    mul_3232 u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        logic [7:0]  chg_edge;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", nm, act, req);
        end
    endtask

    // Called right after a negedge with rst_n just released: walks edges
    // 1..33 and checks the outputs stay idle until edge 33.
    task automatic wait_result(input logic [63:0] exp, input string nm, input int chg_edge);
        logic early;
        early = 1'b0;
        for (int e = 1; e <= 33; e++) begin
            @(negedge clk);
            if (e < 33 && (u_if.ready_n !== 1'b1 || u_if.result !== 64'd0))
                early = 1'b1;
            if (e == chg_edge) begin
                u_if.ina = 32'hFFFF_FFFF;
                u_if.inb = 32'hFFFF_FFFF;
            end
        end
        check({nm, " idle_before_33"}, {63'd0, early}, 64'd0);
        check({nm, " ready_n"}, {63'd0, u_if.ready_n}, 64'd0);
        check({nm, " result"}, u_if.result, exp);
    endtask

    task automatic reset_and_load(input logic [31:0] a, input logic [31:0] b, input string nm);
        rst_n    = 1'b1;
        u_if.ina = a;
        u_if.inb = b;
        @(negedge clk);
        check({nm, " rst_result"}, u_if.result, 64'd0);
        check({nm, " rst_ready_n"}, {63'd0, u_if.ready_n}, 64'd1);
        rst_n = 1'b0;
    endtask

    initial begin
        logic        moved;
        logic [31:0] ra, rb;
        logic [63:0] held;

        vecs[0]  = '{32'h0000_0001, 32'h0000_0001, 64'h0000_0000_0000_0001, 8'd0};
        vecs[1]  = '{32'h0000_0010, 32'h0000_0100, 64'h0000_0000_0000_1000, 8'd0};
        vecs[2]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 8'd0};
        vecs[3]  = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 8'd0};
        vecs[4]  = '{32'h0000_0000, 32'hDEAD_BEEF, 64'h0000_0000_0000_0000, 8'd0};
        vecs[5]  = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, 8'd10};
        vecs[6]  = '{32'h0001_2345, 32'h0000_0100, 64'h0000_0000_0123_4500, 8'd0};
        vecs[7]  = '{32'hDEAD_BEEF, 32'h0000_0001, 64'h0000_0000_DEAD_BEEF, 8'd0};
        vecs[8]  = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 8'd0};
        vecs[9]  = '{32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE, 8'd0};
        vecs[10] = '{32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 8'd0};

        rst_n    = 1'b1;
        u_if.ina = '0;
        u_if.inb = '0;
        @(negedge clk);

        // Reset held for several cycles keeps outputs at reset values.
        moved = 1'b0;
        for (int i = 0; i < 5; i++) begin
            u_if.ina = 32'h1234_0000 + 32'(i);
            @(negedge clk);
            if (u_if.result !== 64'd0 || u_if.ready_n !== 1'b1) moved = 1'b1;
        end
        check("reset_hold", {63'd0, moved}, 64'd0);

        // Basic product, then 200 cycles of hold with changing inputs.
        reset_and_load(32'h1, 32'h1, "basic");
        wait_result(64'h1, "basic", 0);
        moved = 1'b0;
        for (int i = 0; i < 200; i++) begin
            u_if.ina = $urandom;
            u_if.inb = $urandom;
            @(negedge clk);
            if (u_if.result !== 64'h1 || u_if.ready_n !== 1'b0) moved = 1'b1;
        end
        check("done_hold", {63'd0, moved}, 64'd0);

        // Reset while in DONE clears the outputs on that edge.
        rst_n = 1'b1;
        @(negedge clk);
        check("done_rst_result", u_if.result, 64'd0);
        check("done_rst_ready_n", {63'd0, u_if.ready_n}, 64'd1);

        for (int v = 0; v < NVEC; v++) begin
            reset_and_load(vecs[v].a, vecs[v].b, $sformatf("vec%0d", v));
            wait_result(vecs[v].exp, $sformatf("vec%0d", v), int'(vecs[v].chg_edge));
        end

        // Abort mid-run at edge 15, then restart straight away.
        reset_and_load(32'h0000_0007, 32'h0000_0009, "abort");
        for (int e = 1; e <= 14; e++) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_result", u_if.result, 64'd0);
        check("abort_ready_n", {63'd0, u_if.ready_n}, 64'd1);
        u_if.ina = 32'h0001_2345;
        u_if.inb = 32'h0000_0100;
        rst_n    = 1'b0;
        wait_result(64'h0000_0000_0123_4500, "after_abort", 0);

        // Random operands against a 64-bit golden product.
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n == 0) ra = 32'hFFFF_FFFF;
            rst_n    = 1'b1;
            u_if.ina = ra;
            u_if.inb = rb;
            @(negedge clk);
            rst_n = 1'b0;
            for (int e = 1; e <= 33; e++) @(negedge clk);
            held = 64'(ra) * 64'(rb);
            if (u_if.ready_n !== 1'b0) begin
                total++;
                bad++;
                $display("FAIL rand%0d ready_n: got %b expected 0", n, u_if.ready_n);
            end else begin
                check($sformatf("rand%0d %h*%h", n, ra, rb), u_if.result, held);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
